// File: rtl/id_ex_stage.sv
// Decode->Execute pipeline register with Execute-stage condition evaluation.
// Holds the decoded control/data for the instruction in E, owns the NZCV
// flags, and produces the condition-gated control consumed downstream.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              PCSrcD,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic [1:0]        ALUControlD,
  input  logic [1:0]        FlagWriteD,
  input  logic [3:0]        CondD,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [DATA_W-1:0] ExtImmD,
  input  logic [RA_W-1:0]   WA3D,
  input  logic [3:0]        ALUFlags,
  output logic              ALUSrcE,
  output logic [1:0]        ALUControlE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] ExtImmE,
  output logic [RA_W-1:0]   WA3E,
  output logic              CondExE,
  output logic              PCSrcE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              MemtoRegE,
  output logic [3:0]        FlagsE
);

  localparam logic [3:0] COND_AL = 4'b1110;

  logic              pcSrc_q,    pcSrc_d;
  logic              regWrite_q, regWrite_d;
  logic              memtoReg_q, memtoReg_d;
  logic              memWrite_q, memWrite_d;
  logic              branch_q,   branch_d;
  logic              aluSrc_q,   aluSrc_d;
  logic [1:0]        aluControl_q, aluControl_d;
  logic [1:0]        flagWrite_q,  flagWrite_d;
  logic [3:0]        cond_q,     cond_d;
  logic [DATA_W-1:0] rd1_q,      rd1_d;
  logic [DATA_W-1:0] rd2_q,      rd2_d;
  logic [DATA_W-1:0] extImm_q,   extImm_d;
  logic [RA_W-1:0]   wa3_q,      wa3_d;
  logic [3:0]        flags_q,    flags_d;

  logic condEx;
  logic flagN, flagZ, flagC, flagV;
  logic advance;

  assign flagN = flags_q[3];
  assign flagZ = flags_q[2];
  assign flagC = flags_q[1];
  assign flagV = flags_q[0];

  // The E instruction leaves the stage whenever it is not held; a flush
  // overrides the hold, so the outgoing instruction still commits its flags.
  assign advance = FlushE | ~StallE;

  // ARM condition decode of the E instruction against the current flags.
  always_comb begin
    condEx = 1'b0;
    case (cond_q)
      4'h0: condEx = flagZ;
      4'h1: condEx = ~flagZ;
      4'h2: condEx = flagC;
      4'h3: condEx = ~flagC;
      4'h4: condEx = flagN;
      4'h5: condEx = ~flagN;
      4'h6: condEx = flagV;
      4'h7: condEx = ~flagV;
      4'h8: condEx = flagC & ~flagZ;
      4'h9: condEx = ~flagC | flagZ;
      4'hA: condEx = (flagN == flagV);
      4'hB: condEx = (flagN != flagV);
      4'hC: condEx = ~flagZ & (flagN == flagV);
      4'hD: condEx = flagZ | (flagN != flagV);
      4'hE: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

  // Next state of the E register: bubble on flush, hold on stall, else load D.
  always_comb begin
    pcSrc_d      = pcSrc_q;
    regWrite_d   = regWrite_q;
    memtoReg_d   = memtoReg_q;
    memWrite_d   = memWrite_q;
    branch_d     = branch_q;
    aluSrc_d     = aluSrc_q;
    aluControl_d = aluControl_q;
    flagWrite_d  = flagWrite_q;
    cond_d       = cond_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    extImm_d     = extImm_q;
    wa3_d        = wa3_q;
    if (FlushE) begin
      pcSrc_d      = 1'b0;
      regWrite_d   = 1'b0;
      memtoReg_d   = 1'b0;
      memWrite_d   = 1'b0;
      branch_d     = 1'b0;
      aluSrc_d     = 1'b0;
      aluControl_d = 2'b00;
      flagWrite_d  = 2'b00;
      cond_d       = COND_AL;
      rd1_d        = '0;
      rd2_d        = '0;
      extImm_d     = '0;
      wa3_d        = '0;
    end else if (!StallE) begin
      pcSrc_d      = PCSrcD;
      regWrite_d   = RegWriteD;
      memtoReg_d   = MemtoRegD;
      memWrite_d   = MemWriteD;
      branch_d     = BranchD;
      aluSrc_d     = ALUSrcD;
      aluControl_d = ALUControlD;
      flagWrite_d  = FlagWriteD;
      cond_d       = CondD;
      rd1_d        = RD1D;
      rd2_d        = RD2D;
      extImm_d     = ExtImmD;
      wa3_d        = WA3D;
    end
  end

  // Flags commit only when the E instruction moves on and its condition passed.
  always_comb begin
    flags_d = flags_q;
    if (advance && condEx) begin
      if (flagWrite_q[1]) flags_d[3:2] = ALUFlags[3:2];
      if (flagWrite_q[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  // State update with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcSrc_q      <= 1'b0;
      regWrite_q   <= 1'b0;
      memtoReg_q   <= 1'b0;
      memWrite_q   <= 1'b0;
      branch_q     <= 1'b0;
      aluSrc_q     <= 1'b0;
      aluControl_q <= 2'b00;
      flagWrite_q  <= 2'b00;
      cond_q       <= 4'b0000;
      rd1_q        <= '0;
      rd2_q        <= '0;
      extImm_q     <= '0;
      wa3_q        <= '0;
      flags_q      <= 4'b0000;
    end else begin
      pcSrc_q      <= pcSrc_d;
      regWrite_q   <= regWrite_d;
      memtoReg_q   <= memtoReg_d;
      memWrite_q   <= memWrite_d;
      branch_q     <= branch_d;
      aluSrc_q     <= aluSrc_d;
      aluControl_q <= aluControl_d;
      flagWrite_q  <= flagWrite_d;
      cond_q       <= cond_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      extImm_q     <= extImm_d;
      wa3_q        <= wa3_d;
      flags_q      <= flags_d;
    end
  end

  assign ALUSrcE     = aluSrc_q;
  assign ALUControlE = aluControl_q;
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign ExtImmE     = extImm_q;
  assign WA3E        = wa3_q;
  assign CondExE     = condEx;
  assign PCSrcE      = (pcSrc_q | branch_q) & condEx;
  assign RegWriteE   = regWrite_q & condEx;
  assign MemWriteE   = memWrite_q & condEx;
  assign MemtoRegE   = memtoReg_q;
  assign FlagsE      = flags_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected E-stage outputs are queued as each
// instruction is driven and compared once the clock edge has taken it into E.
module tb_id_ex_stage;

  logic        clk;
  logic        reset;
  logic        StallE, FlushE;
  logic        PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD;
  logic [1:0]  ALUControlD, FlagWriteD;
  logic [3:0]  CondD;
  logic [31:0] RD1D, RD2D, ExtImmD;
  logic [3:0]  WA3D;
  logic [3:0]  ALUFlags;
  logic        ALUSrcE;
  logic [1:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ExtImmE;
  logic [3:0]  WA3E;
  logic        CondExE, PCSrcE, RegWriteE, MemWriteE, MemtoRegE;
  logic [3:0]  FlagsE;

  typedef struct {
    logic        regWrite;
    logic        memWrite;
    logic        memtoReg;
    logic        pcSrc;
    logic        condEx;
    logic        aluSrc;
    logic [1:0]  aluControl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] extImm;
    logic [3:0]  wa3;
    logic [3:0]  flags;
  } exp_t;

  exp_t expQ[$];
  int   testCount = 0;
  int   failCount = 0;

  id_ex_stage #(.DATA_W(32), .RA_W(4)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
    .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD), .CondD(CondD),
    .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD), .WA3D(WA3D),
    .ALUFlags(ALUFlags),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
    .ExtImmE(ExtImmE), .WA3E(WA3E), .CondExE(CondExE), .PCSrcE(PCSrcE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .FlagsE(FlagsE)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clearD();
    PCSrcD = 0; RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; BranchD = 0;
    ALUSrcD = 0; ALUControlD = 0; FlagWriteD = 0; CondD = 4'hE;
    RD1D = 0; RD2D = 0; ExtImmD = 0; WA3D = 0; ALUFlags = 0;
  endtask

  task automatic pushExp(input logic rw, input logic mw, input logic mtr,
                         input logic pcs, input logic cex, input logic asrc,
                         input logic [1:0] actl, input logic [31:0] rd1,
                         input logic [31:0] rd2, input logic [31:0] imm,
                         input logic [3:0] wa3, input logic [3:0] flags);
    exp_t e;
    e.regWrite = rw;  e.memWrite = mw; e.memtoReg = mtr; e.pcSrc = pcs;
    e.condEx = cex;   e.aluSrc = asrc; e.aluControl = actl;
    e.rd1 = rd1; e.rd2 = rd2; e.extImm = imm; e.wa3 = wa3; e.flags = flags;
    expQ.push_back(e);
  endtask

  task automatic checkField(input string tag, input logic [31:0] obs,
                            input logic [31:0] expv);
    testCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string step);
    exp_t e;
    testCount++;
    assert (expQ.size() > 0) else begin
      failCount++;
      $error("[TB] FAIL %s scoreboard empty observed=0 expected=1", step);
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkField({step, ".RegWriteE"},   {31'd0, RegWriteE},   {31'd0, e.regWrite});
      checkField({step, ".MemWriteE"},   {31'd0, MemWriteE},   {31'd0, e.memWrite});
      checkField({step, ".MemtoRegE"},   {31'd0, MemtoRegE},   {31'd0, e.memtoReg});
      checkField({step, ".PCSrcE"},      {31'd0, PCSrcE},      {31'd0, e.pcSrc});
      checkField({step, ".CondExE"},     {31'd0, CondExE},     {31'd0, e.condEx});
      checkField({step, ".ALUSrcE"},     {31'd0, ALUSrcE},     {31'd0, e.aluSrc});
      checkField({step, ".ALUControlE"}, {30'd0, ALUControlE}, {30'd0, e.aluControl});
      checkField({step, ".RD1E"},        RD1E,                 e.rd1);
      checkField({step, ".RD2E"},        RD2E,                 e.rd2);
      checkField({step, ".ExtImmE"},     ExtImmE,              e.extImm);
      checkField({step, ".WA3E"},        {28'd0, WA3E},        {28'd0, e.wa3});
      checkField({step, ".FlagsE"},      {28'd0, FlagsE},      {28'd0, e.flags});
    end
  endtask

  // Drive stall/flush, take one rising edge, then compare shortly after it.
  task automatic applyStimulus(input string step, input logic stall, input logic flush);
    StallE = stall;
    FlushE = flush;
    @(posedge clk);
    #1;
    checkOutput(step);
  endtask

  initial begin
    reset = 1'b0; StallE = 0; FlushE = 0;
    clearD();
    #2;
    pushExp(0,0,0,0,0,0,2'd0,32'h0,32'h0,32'h0,4'h0,4'b0000);
    checkOutput("reset");
    @(negedge clk);
    reset = 1'b1;

    // Plain load with all data fields populated.
    clearD(); RegWriteD = 1; MemtoRegD = 1; ALUSrcD = 1; ALUControlD = 2;
    RD1D = 32'h1234; RD2D = 32'h5678; ExtImmD = 32'hAB; WA3D = 4'd3;
    pushExp(1,0,1,0,1,1,2'd2,32'h1234,32'h5678,32'hAB,4'd3,4'b0000);
    applyStimulus("load", 0, 0);

    // Flag-setting instruction enters E.
    clearD(); RegWriteD = 1; FlagWriteD = 2'b11; RD1D = 32'h1; ALUFlags = 4'b0100;
    pushExp(1,0,0,0,1,0,2'd0,32'h1,32'h0,32'h0,4'd0,4'b0000);
    applyStimulus("flagset", 0, 0);

    // EQ store: flags committed to 0100 on this edge, Z=1 passes.
    clearD(); CondD = 4'h0; MemWriteD = 1; ALUFlags = 4'b0100;
    pushExp(0,1,0,0,1,0,2'd0,32'h0,32'h0,32'h0,4'd0,4'b0100);
    applyStimulus("eq_store", 0, 0);

    // NE store suppressed; ALUFlags ignored since E instr writes no flags.
    clearD(); CondD = 4'h1; MemWriteD = 1; ALUFlags = 4'b1111;
    pushExp(0,0,0,0,0,0,2'd0,32'h0,32'h0,32'h0,4'd0,4'b0100);
    applyStimulus("ne_store", 0, 0);

    // Instruction that updates C,V once it leaves E.
    clearD(); RegWriteD = 1; FlagWriteD = 2'b01; RD1D = 32'hAAAA; WA3D = 4'd7;
    pushExp(1,0,0,0,1,0,2'd0,32'hAAAA,32'h0,32'h0,4'd7,4'b0100);
    applyStimulus("cv_writer", 0, 0);

    // Stall three cycles with changing D: E contents and flags hold.
    for (int i = 0; i < 3; i++) begin
      clearD(); RegWriteD = 1; FlagWriteD = 2'b11; CondD = 4'h1;
      RD1D = 32'h100 + i; WA3D = 4'(i + 1); ALUFlags = 4'b0011;
      pushExp(1,0,0,0,1,0,2'd0,32'hAAAA,32'h0,32'h0,4'd7,4'b0100);
      applyStimulus($sformatf("stall%0d", i), 1, 0);
    end

    // Release: current D loads, held instr commits C,V=11.
    clearD(); MemWriteD = 1; RD1D = 32'h3333; RD2D = 32'h4444; ExtImmD = 32'h55;
    WA3D = 4'd9; ALUControlD = 1; ALUFlags = 4'b0011;
    pushExp(0,1,0,0,1,0,2'd1,32'h3333,32'h4444,32'h55,4'd9,4'b0111);
    applyStimulus("unstall", 0, 0);

    // Flush with stall: bubble with AL condition.
    clearD(); RegWriteD = 1; MemWriteD = 1; BranchD = 1; PCSrcD = 1; MemtoRegD = 1;
    CondD = 4'h0; RD1D = 32'hFFFF; WA3D = 4'd5; FlagWriteD = 2'b11; ALUFlags = 4'b1000;
    pushExp(0,0,0,0,1,0,2'd0,32'h0,32'h0,32'h0,4'd0,4'b0111);
    applyStimulus("flush", 1, 1);

    // NZCV writer, then LT branch with N=1,V=0 taken.
    clearD(); FlagWriteD = 2'b11;
    pushExp(0,0,0,0,1,0,2'd0,32'h0,32'h0,32'h0,4'd0,4'b0111);
    applyStimulus("nzcv_writer", 0, 0);
    clearD(); BranchD = 1; CondD = 4'hB; ALUFlags = 4'b1000;
    pushExp(0,0,0,1,1,0,2'd0,32'h0,32'h0,32'h0,4'd0,4'b1000);
    applyStimulus("lt_taken", 0, 0);

    // CV writer, then LT branch with N=1,V=1 not taken.
    clearD(); FlagWriteD = 2'b01; ALUFlags = 4'b0111;
    pushExp(0,0,0,0,1,0,2'd0,32'h0,32'h0,32'h0,4'd0,4'b1000);
    applyStimulus("cv_writer2", 0, 0);
    clearD(); BranchD = 1; CondD = 4'hB; ALUFlags = 4'b0001;
    pushExp(0,0,0,0,0,0,2'd0,32'h0,32'h0,32'h0,4'd0,4'b1001);
    applyStimulus("lt_not_taken", 0, 0);

    // GE with PCSrc and RegWrite passes.
    clearD(); PCSrcD = 1; RegWriteD = 1; CondD = 4'hA;
    pushExp(1,0,0,1,1,0,2'd0,32'h0,32'h0,32'h0,4'd0,4'b1001);
    applyStimulus("ge_pc", 0, 0);

    // Never-condition: gates RegWrite, MemtoReg stays ungated.
    clearD(); CondD = 4'hF; FlagWriteD = 2'b11; RegWriteD = 1; MemtoRegD = 1;
    pushExp(0,0,1,0,0,0,2'd0,32'h0,32'h0,32'h0,4'd0,4'b1001);
    applyStimulus("never", 0, 0);

    // Failed-condition instr must not update flags; HI fails with C=0.
    clearD(); CondD = 4'h8; ALUFlags = 4'b0110;
    pushExp(0,0,0,0,0,0,2'd0,32'h0,32'h0,32'h0,4'd0,4'b1001);
    applyStimulus("hi_fail", 0, 0);

    // GT passes with Z=0, N==V.
    clearD(); CondD = 4'hC; RegWriteD = 1; RD2D = 32'hBEEF;
    pushExp(1,0,0,0,1,0,2'd0,32'h0,32'hBEEF,32'h0,4'd0,4'b1001);
    applyStimulus("gt_pass", 0, 0);

    // Asynchronous reset between edges clears everything immediately.
    #2;
    reset = 1'b0;
    #1;
    pushExp(0,0,0,0,0,0,2'd0,32'h0,32'h0,32'h0,4'd0,4'b0000);
    checkOutput("async_reset");
    @(negedge clk);
    reset = 1'b1;

    // After reset flags are zero, so EQ fails.
    clearD(); CondD = 4'h0; RegWriteD = 1; RD1D = 32'h77;
    pushExp(0,0,0,0,0,0,2'd0,32'h77,32'h0,32'h0,4'd0,4'b0000);
    applyStimulus("post_reset_eq", 0, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
